tlb_storage: RTL and testbench

Entry storage array for a set-associative TLB: NUM_SETS sets × NUM_WAYS ways, each entry holding valid, VPN, PPN, permission bits and an LRU counter. It sits under the TLB lookup and replacement logic. The lookup logic reads all ways of one set combinationally; the refill and replacement logic writes whole entries and updates single LRU counters on the clock edge. The block does no tag compare, hit detection or victim selection.

---
 rtl/tlb_storage_pkg.sv | 27 ++
 rtl/tlb_storage_way.sv | 71 +++++++
 rtl/tlb_storage.sv | 76 +++++++
 tb/tb_tlb_storage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_storage_pkg.sv
// Shared TLB parameters and field types, imported by the storage, lookup,
// replacement logic and the bench.
package tlb_storage_pkg;

    localparam int unsigned NUM_SETS       = 16;
    localparam int unsigned NUM_WAYS       = 4;
    localparam int unsigned SET_INDEX_BITS = 4;
    localparam int unsigned LRU_BITS       = 4;

    localparam int unsigned VPN_BITS  = 20;
    localparam int unsigned PPN_BITS  = 20;
    localparam int unsigned PERM_BITS = 2;

    // Way select width is fixed by the port list (wr_way / lru_way).
    localparam int unsigned WAY_SEL_BITS = 2;

    typedef logic [VPN_BITS-1:0]     vpn_t;
    typedef logic [PPN_BITS-1:0]     ppn_t;
    typedef logic [PERM_BITS-1:0]    perm_t;
    typedef logic [WAY_SEL_BITS-1:0] way_sel_t;

    // True when a way-select bus addresses the given way number.
    function automatic logic way_match(input way_sel_t sel, input int unsigned way);
        return (sel == way_sel_t'(way));
    endfunction

endpackage

// File: rtl/tlb_storage_way.sv
// One way of the TLB entry array: NUM_SETS entries with per-field registers,
// combinational read of the selected set.
module tlb_storage_way
    import tlb_storage_pkg::*;
#(
    parameter int unsigned NUM_SETS       = tlb_storage_pkg::NUM_SETS,
    parameter int unsigned SET_INDEX_BITS = tlb_storage_pkg::SET_INDEX_BITS,
    parameter int unsigned LRU_BITS       = tlb_storage_pkg::LRU_BITS
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [SET_INDEX_BITS-1:0] rd_set_index,
    output logic                      rd_valid,
    output vpn_t                      rd_vpn,
    output ppn_t                      rd_ppn,
    output perm_t                     rd_perms,
    output logic [LRU_BITS-1:0]       rd_lru_count,

    input  logic                      wr_en,
    input  logic [SET_INDEX_BITS-1:0] wr_set_index,
    input  logic                      wr_valid,
    input  vpn_t                      wr_vpn,
    input  ppn_t                      wr_ppn,
    input  perm_t                     wr_perms,
    input  logic [LRU_BITS-1:0]       wr_lru_count,

    input  logic                      lru_update_en,
    input  logic [SET_INDEX_BITS-1:0] lru_set_index,
    input  logic [LRU_BITS-1:0]       lru_value
);

    logic [NUM_SETS-1:0]                valid_q;
    logic [NUM_SETS-1:0][VPN_BITS-1:0]  vpn_q;
    logic [NUM_SETS-1:0][PPN_BITS-1:0]  ppn_q;
    logic [NUM_SETS-1:0][PERM_BITS-1:0] perms_q;
    logic [NUM_SETS-1:0][LRU_BITS-1:0]  lru_q;

    // Entry update: reset clears all, then full write, then LRU-only update
    // (placed last so it overrides the written LRU on the same entry).
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            vpn_q   <= '0;
            ppn_q   <= '0;
            perms_q <= '0;
            lru_q   <= '0;
        end else begin
            if (wr_en) begin
                valid_q[wr_set_index] <= wr_valid;
                vpn_q[wr_set_index]   <= wr_vpn;
                ppn_q[wr_set_index]   <= wr_ppn;
                perms_q[wr_set_index] <= wr_perms;
                lru_q[wr_set_index]   <= wr_lru_count;
            end
            if (lru_update_en) begin
                lru_q[lru_set_index] <= lru_value;
            end
        end
    end

    // Unregistered read of the selected set; no bypass of pending writes.
    always_comb begin
        rd_valid     = valid_q[rd_set_index];
        rd_vpn       = vpn_q[rd_set_index];
        rd_ppn       = ppn_q[rd_set_index];
        rd_perms     = perms_q[rd_set_index];
        rd_lru_count = lru_q[rd_set_index];
    end

endmodule

// File: rtl/tlb_storage.sv
// Set-associative TLB entry storage: NUM_SETS x NUM_WAYS entries, all ways
// of one set read combinationally, whole-entry writes and LRU-only updates.
module tlb_storage
    import tlb_storage_pkg::*;
#(
    parameter int unsigned NUM_SETS       = tlb_storage_pkg::NUM_SETS,
    parameter int unsigned NUM_WAYS       = tlb_storage_pkg::NUM_WAYS,
    parameter int unsigned SET_INDEX_BITS = tlb_storage_pkg::SET_INDEX_BITS,
    parameter int unsigned LRU_BITS       = tlb_storage_pkg::LRU_BITS
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [SET_INDEX_BITS-1:0] rd_set_index,
    output logic                      rd_valid     [0:NUM_WAYS-1],
    output logic [VPN_BITS-1:0]       rd_vpn       [0:NUM_WAYS-1],
    output logic [PPN_BITS-1:0]       rd_ppn       [0:NUM_WAYS-1],
    output logic [PERM_BITS-1:0]      rd_perms     [0:NUM_WAYS-1],
    output logic [LRU_BITS-1:0]       rd_lru_count [0:NUM_WAYS-1],

    input  logic                      wr_en,
    input  logic [SET_INDEX_BITS-1:0] wr_set_index,
    input  logic [1:0]                wr_way,
    input  logic                      wr_valid,
    input  logic [VPN_BITS-1:0]       wr_vpn,
    input  logic [PPN_BITS-1:0]       wr_ppn,
    input  logic [PERM_BITS-1:0]      wr_perms,
    input  logic [LRU_BITS-1:0]       wr_lru_count,

    input  logic                      lru_update_en,
    input  logic [SET_INDEX_BITS-1:0] lru_set_index,
    input  logic [1:0]                lru_way,
    input  logic [LRU_BITS-1:0]       lru_value
);

    logic [NUM_WAYS-1:0] way_wr_en;
    logic [NUM_WAYS-1:0] way_lru_en;

    // Decode the way selects into per-way strobes.
    always_comb begin
        way_wr_en  = '0;
        way_lru_en = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            way_wr_en[w]  = wr_en && way_match(wr_way, w);
            way_lru_en[w] = lru_update_en && way_match(lru_way, w);
        end
    end

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        tlb_storage_way #(
            .NUM_SETS       (NUM_SETS),
            .SET_INDEX_BITS (SET_INDEX_BITS),
            .LRU_BITS       (LRU_BITS)
        ) u_way (
            .clk           (clk),
            .rst           (rst),
            .rd_set_index  (rd_set_index),
            .rd_valid      (rd_valid[w]),
            .rd_vpn        (rd_vpn[w]),
            .rd_ppn        (rd_ppn[w]),
            .rd_perms      (rd_perms[w]),
            .rd_lru_count  (rd_lru_count[w]),
            .wr_en         (way_wr_en[w]),
            .wr_set_index  (wr_set_index),
            .wr_valid      (wr_valid),
            .wr_vpn        (wr_vpn),
            .wr_ppn        (wr_ppn),
            .wr_perms      (wr_perms),
            .wr_lru_count  (wr_lru_count),
            .lru_update_en (way_lru_en[w]),
            .lru_set_index (lru_set_index),
            .lru_value     (lru_value)
        );
    end

endmodule

// File: tb/tb_tlb_storage.sv
// Bench for tlb_storage: entry-level reference model compared every cycle,
// plus directed writes with literal expected read-back values.
module tb_tlb_storage;
    import tlb_storage_pkg::*;

    localparam int NS = 16;
    localparam int NW = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rd_set_index;
    logic       rd_valid     [0:NW-1];
    logic [19:0] rd_vpn      [0:NW-1];
    logic [19:0] rd_ppn      [0:NW-1];
    logic [1:0] rd_perms     [0:NW-1];
    logic [3:0] rd_lru_count [0:NW-1];
    logic       wr_en;
    logic [3:0] wr_set_index;
    logic [1:0] wr_way;
    logic       wr_valid;
    logic [19:0] wr_vpn;
    logic [19:0] wr_ppn;
    logic [1:0] wr_perms;
    logic [3:0] wr_lru_count;
    logic       lru_update_en;
    logic [3:0] lru_set_index;
    logic [1:0] lru_way;
    logic [3:0] lru_value;

    always #5 clk = ~clk;

    tlb_storage #(
        .NUM_SETS       (16),
        .NUM_WAYS       (4),
        .SET_INDEX_BITS (4),
        .LRU_BITS       (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_set_index  (rd_set_index),
        .rd_valid      (rd_valid),
        .rd_vpn        (rd_vpn),
        .rd_ppn        (rd_ppn),
        .rd_perms      (rd_perms),
        .rd_lru_count  (rd_lru_count),
        .wr_en         (wr_en),
        .wr_set_index  (wr_set_index),
        .wr_way        (wr_way),
        .wr_valid      (wr_valid),
        .wr_vpn        (wr_vpn),
        .wr_ppn        (wr_ppn),
        .wr_perms      (wr_perms),
        .wr_lru_count  (wr_lru_count),
        .lru_update_en (lru_update_en),
        .lru_set_index (lru_set_index),
        .lru_way       (lru_way),
        .lru_value     (lru_value)
    );

    typedef struct {
        logic        v;
        logic [19:0] vpn;
        logic [19:0] ppn;
        logic [1:0]  p;
        logic [3:0]  lru;
    } ent_t;

    ent_t model [NS][NW];
    int   checks   = 0;
    int   failures = 0;
    bit   ready    = 1'b0;

    // Reference model: the table of entries as the TLB sees it.
    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NS; s++)
                for (int w = 0; w < NW; w++)
                    model[s][w] = '{v: 1'b0, vpn: 20'h0, ppn: 20'h0, p: 2'b0, lru: 4'h0};
        end else begin
            if (wr_en)
                model[wr_set_index][wr_way] = '{v: wr_valid, vpn: wr_vpn, ppn: wr_ppn,
                                                p: wr_perms, lru: wr_lru_count};
            if (lru_update_en)
                model[lru_set_index][lru_way].lru = lru_value;
        end
    end

    // Every cycle: all ways of the selected set must match the model.
    always @(negedge clk) begin
        if (ready) begin
            for (int w = 0; w < NW; w++) begin
                ent_t e;
                e = model[rd_set_index][w];
                checks++;
                if ({rd_valid[w], rd_vpn[w], rd_ppn[w], rd_perms[w], rd_lru_count[w]}
                    !== {e.v, e.vpn, e.ppn, e.p, e.lru}) begin
                    failures++;
                    $display("FAIL model_cmp set=%0d way=%0d actual=%b/%h/%h/%b/%h required=%b/%h/%h/%b/%h",
                             rd_set_index, w, rd_valid[w], rd_vpn[w], rd_ppn[w], rd_perms[w],
                             rd_lru_count[w], e.v, e.vpn, e.ppn, e.p, e.lru);
                end
            end
        end
    end

    task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Literal expectation on one entry: {valid, vpn, ppn, perms, lru}.
    task automatic expect_entry(input string nm, input logic [3:0] s, input int w,
                                input logic v, input logic [19:0] vpn, input logic [19:0] ppn,
                                input logic [1:0] p, input logic [3:0] l);
        rd_set_index = s;
        #1;
        lit(nm, 64'({rd_valid[w], rd_vpn[w], rd_ppn[w], rd_perms[w], rd_lru_count[w]}),
                64'({v, vpn, ppn, p, l}));
    endtask

    task automatic do_write(input logic [3:0] s, input logic [1:0] w, input logic v,
                            input logic [19:0] vpn, input logic [19:0] ppn,
                            input logic [1:0] p, input logic [3:0] l);
        wr_set_index = s;
        wr_way       = w;
        wr_valid     = v;
        wr_vpn       = vpn;
        wr_ppn       = ppn;
        wr_perms     = p;
        wr_lru_count = l;
        wr_en        = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // Walk every set, one per cycle, requiring all-zero contents.
    task automatic scan_zero(input string nm);
        for (int s = 0; s < NS; s++) begin
            rd_set_index = 4'(s);
            #1;
            for (int w = 0; w < NW; w++)
                lit(nm, 64'({rd_valid[w], rd_vpn[w], rd_ppn[w], rd_perms[w], rd_lru_count[w]}), 64'h0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        rd_set_index = '0;
        wr_en = 1'b0; wr_set_index = '0; wr_way = '0; wr_valid = 1'b0;
        wr_vpn = '0; wr_ppn = '0; wr_perms = '0; wr_lru_count = '0;
        lru_update_en = 1'b0; lru_set_index = '0; lru_way = '0; lru_value = '0;

        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        ready = 1'b1;
        scan_zero("reset_zero");

        // Single write, with read-during-write showing old contents first.
        rd_set_index = 4'd5;
        wr_set_index = 4'd5; wr_way = 2'd2; wr_valid = 1'b1;
        wr_vpn = 20'hABCDE; wr_ppn = 20'h12345; wr_perms = 2'b11; wr_lru_count = 4'h0;
        wr_en = 1'b1;
        #1;
        lit("rdw_old_valid", 64'(rd_valid[2]), 64'h0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        expect_entry("single_w2", 4'd5, 2, 1'b1, 20'hABCDE, 20'h12345, 2'b11, 4'h0);
        lit("single_w0_inv", 64'(rd_valid[0]), 64'h0);
        lit("single_w1_inv", 64'(rd_valid[1]), 64'h0);
        lit("single_w3_inv", 64'(rd_valid[3]), 64'h0);

        // Fill set 3, then overwrite way 1.
        do_write(4'd3, 2'd0, 1'b1, 20'h11111, 20'h22222, 2'b01, 4'h1);
        do_write(4'd3, 2'd1, 1'b1, 20'h33333, 20'h44444, 2'b10, 4'h2);
        do_write(4'd3, 2'd2, 1'b1, 20'h55555, 20'h66666, 2'b11, 4'h3);
        do_write(4'd3, 2'd3, 1'b1, 20'h77777, 20'h88888, 2'b00, 4'h4);
        expect_entry("fill_w0", 4'd3, 0, 1'b1, 20'h11111, 20'h22222, 2'b01, 4'h1);
        expect_entry("fill_w1", 4'd3, 1, 1'b1, 20'h33333, 20'h44444, 2'b10, 4'h2);
        expect_entry("fill_w2", 4'd3, 2, 1'b1, 20'h55555, 20'h66666, 2'b11, 4'h3);
        expect_entry("fill_w3", 4'd3, 3, 1'b1, 20'h77777, 20'h88888, 2'b00, 4'h4);
        do_write(4'd3, 2'd1, 1'b1, 20'hAAAAA, 20'hBBBBB, 2'b11, 4'h2);
        expect_entry("over_w0", 4'd3, 0, 1'b1, 20'h11111, 20'h22222, 2'b01, 4'h1);
        expect_entry("over_w1", 4'd3, 1, 1'b1, 20'hAAAAA, 20'hBBBBB, 2'b11, 4'h2);
        expect_entry("over_w2", 4'd3, 2, 1'b1, 20'h55555, 20'h66666, 2'b11, 4'h3);
        expect_entry("over_w3", 4'd3, 3, 1'b1, 20'h77777, 20'h88888, 2'b00, 4'h4);

        // LRU-only update leaves the rest of the entry alone.
        do_write(4'd7, 2'd0, 1'b1, 20'h99999, 20'hEEEEE, 2'b01, 4'h0);
        lru_set_index = 4'd7; lru_way = 2'd0; lru_value = 4'hF; lru_update_en = 1'b1;
        @(posedge clk);
        #1;
        lru_update_en = 1'b0;
        expect_entry("lru_upd", 4'd7, 0, 1'b1, 20'h99999, 20'hEEEEE, 2'b01, 4'hF);

        // Way 0 of every set, then read all back for aliasing.
        for (int i = 0; i < NS; i++)
            do_write(4'(i), 2'd0, 1'b1, 20'h10000 + 20'(i), 20'h20000 + 20'(i), 2'b10, 4'(i));
        for (int i = 0; i < NS; i++) begin
            expect_entry("all_sets", 4'(i), 0, 1'b1, 20'h10000 + 20'(i), 20'h20000 + 20'(i), 2'b10, 4'(i));
            @(posedge clk);
            #1;
        end

        // Same-entry collision: LRU update overrides the written LRU.
        lru_set_index = 4'd8; lru_way = 2'd1; lru_value = 4'd10; lru_update_en = 1'b1;
        do_write(4'd8, 2'd1, 1'b1, 20'hCCCCC, 20'hDDDDD, 2'b10, 4'd5);
        lru_update_en = 1'b0;
        expect_entry("collide_same", 4'd8, 1, 1'b1, 20'hCCCCC, 20'hDDDDD, 2'b10, 4'd10);

        // Different entries in one cycle: both land.
        lru_set_index = 4'd8; lru_way = 2'd1; lru_value = 4'd3; lru_update_en = 1'b1;
        do_write(4'd9, 2'd2, 1'b1, 20'h0F0F0, 20'hF0F0F, 2'b01, 4'd7);
        lru_update_en = 1'b0;
        expect_entry("collide_diff_lru", 4'd8, 1, 1'b1, 20'hCCCCC, 20'hDDDDD, 2'b10, 4'd3);
        expect_entry("collide_diff_wr", 4'd9, 2, 1'b1, 20'h0F0F0, 20'hF0F0F, 2'b01, 4'd7);

        // Held LRU strobe rewrites on each edge with the current value.
        lru_set_index = 4'd9; lru_way = 2'd2; lru_value = 4'd1; lru_update_en = 1'b1;
        @(posedge clk);
        #1;
        lru_value = 4'd2;
        @(posedge clk);
        #1;
        lru_update_en = 1'b0;
        expect_entry("held_lru", 4'd9, 2, 1'b1, 20'h0F0F0, 20'hF0F0F, 2'b01, 4'd2);

        // Reset wins over strobes presented in the same cycle.
        rst = 1'b1;
        wr_set_index = 4'd4; wr_way = 2'd3; wr_valid = 1'b1; wr_vpn = 20'h13579;
        wr_ppn = 20'h24680; wr_perms = 2'b11; wr_lru_count = 4'd9; wr_en = 1'b1;
        lru_set_index = 4'd4; lru_way = 2'd3; lru_value = 4'd6; lru_update_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0; lru_update_en = 1'b0;
        scan_zero("midreset_zero");

        ready = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
